dcache_control: RTL and testbench

//  Sequencing FSM for the direct-mapped, write-back L1 data cache. Sits between the CPU memory port and

---
 rtl/dcache_types_pkg.sv | 6 +
 rtl/dcache_control_sat_counter.sv | 13 +
 rtl/dcache_control.sv | 105 ++++++++++
 tb/tb_dcache_control.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dcache_types_pkg.sv
// dcache_types_pkg: shared state and select encodings for the L1 data cache controller.
package dcache_types_pkg;
    typedef enum logic [1:0] {S_IDLE, S_TAG, S_WB, S_ALLOC} dcache_state_t;
    typedef enum logic {DATA_CPU = 1'b0, DATA_PMEM = 1'b1} datasel_t;
    typedef enum logic {PADDR_CPU = 1'b0, PADDR_WB = 1'b1} paddrsel_t;
endpackage

// File: rtl/dcache_control_sat_counter.sv
// sat_counter: statistics counter that sticks at all-ones; clr takes priority over inc.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk)
        count <= (rst || clr) ? '0 : (inc && !(&count)) ? count + 1'b1 : count;
endmodule

// File: rtl/dcache_control.sv
// dcache_control: sequencing FSM for a direct-mapped write-back L1 data cache,
// with saturating hit/miss statistics.
module dcache_control
    import dcache_types_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 hit,
    input  logic                 dirty,
    input  logic                 valid,
    input  logic                 pmem_resp,
    input  logic                 clear_stats,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic                 pmem_addr_sel,
    output logic                 data_sel,
    output logic                 load_data,
    output logic                 load_tag,
    output logic                 load_dirty,
    output logic                 dirty_in,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);
    dcache_state_t state, next_state;
    logic retry, next_retry, hit_inc, miss_inc;
    logic req;

    assign req = mem_read | mem_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            retry <= 1'b0;
        end else begin
            state <= next_state;
            retry <= next_retry;
        end
    end

    // retry marks a request already counted as a miss, so the post-fill hit is not counted
    always_comb begin
        next_state    = state;
        next_retry    = retry;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = PADDR_CPU;
        data_sel      = DATA_CPU;
        load_data     = 1'b0;
        load_tag      = 1'b0;
        load_dirty    = 1'b0;
        dirty_in      = 1'b0;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        case (state)
            S_IDLE: next_state = req ? S_TAG : S_IDLE;
            S_TAG: begin
                if (!req) begin
                    next_state = S_IDLE;
                    next_retry = 1'b0;
                end else if (hit) begin
                    mem_resp   = 1'b1;
                    load_data  = mem_write;
                    load_dirty = mem_write;
                    dirty_in   = mem_write;
                    hit_inc    = !retry;
                    next_retry = 1'b0;
                    next_state = S_IDLE;
                end else begin
                    miss_inc   = !retry;
                    next_retry = 1'b1;
                    next_state = (valid && dirty) ? S_WB : S_ALLOC;
                end
            end
            S_WB: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = PADDR_WB;
                load_dirty    = pmem_resp;
                next_state    = pmem_resp ? S_ALLOC : S_WB;
            end
            S_ALLOC: begin
                pmem_read  = 1'b1;
                data_sel   = pmem_resp ? DATA_PMEM : DATA_CPU;
                load_data  = pmem_resp;
                load_tag   = pmem_resp;
                load_dirty = pmem_resp;
                next_state = pmem_resp ? S_TAG : S_ALLOC;
            end
            default: next_state = S_IDLE;
        endcase
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk(clk), .rst(rst), .clr(clear_stats), .inc(hit_inc), .count(hit_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk(clk), .rst(rst), .clr(clear_stats), .inc(miss_inc), .count(miss_count)
    );
endmodule

// File: tb/tb_dcache_control.sv
// tb_dcache_control: transaction-level random bench for dcache_control with 4-bit counters
// so saturation is reachable; expected outputs come from the per-request cycle script.
module tb_dcache_control;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0, rst = 1'b1;
    logic mem_read = 1'b0, mem_write = 1'b0, hit = 1'b0, dirty = 1'b0, valid = 1'b0;
    logic pmem_resp = 1'b0, clear_stats = 1'b0;
    logic mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_sel;
    logic load_data, load_tag, load_dirty, dirty_in;
    logic [CW-1:0] hit_count, miss_count;

    int tests = 0, fails = 0;
    int m_hits = 0, m_misses = 0;

    dcache_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .hit(hit),
        .dirty(dirty), .valid(valid), .pmem_resp(pmem_resp), .clear_stats(clear_stats),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_addr_sel(pmem_addr_sel), .data_sel(data_sel), .load_data(load_data),
        .load_tag(load_tag), .load_dirty(load_dirty), .dirty_in(dirty_in),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bit order: mem_resp pmem_read pmem_write addr_sel data_sel load_data load_tag load_dirty dirty_in
    task automatic outs(input string tag, input logic [8:0] exp);
        chk(tag, {23'd0, mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_sel,
                  load_data, load_tag, load_dirty, dirty_in}, {23'd0, exp});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bump(inout int c);
        if (c < CMAX) c++;
    endtask

    task automatic counts(input string tag);
        chk({tag, "_hits"}, 32'(hit_count), m_hits);
        chk({tag, "_misses"}, 32'(miss_count), m_misses);
    endtask

    task automatic pmem_phase(input bit wb, input int lat, input bit drop);
        for (int k = 0; k < lat; k++) begin
            bit last = (k == lat - 1);
            pmem_resp = last;
            if (drop && k == 0) begin
                mem_read = 1'b0;
                mem_write = 1'b0;
            end
            #1;
            if (wb) outs("wb", {3'b001, 1'b1, 1'b0, 1'b0, 1'b0, last, 1'b0});
            else    outs("fill", {3'b010, 1'b0, last, last, last, last, 1'b0});
            tick;
        end
        pmem_resp = 1'b0;
    endtask

    // one CPU request: drop_tag withdraws in the tag cycle, drop_fill during the fill
    task automatic do_req(input bit wr, input bit h, input bit v, input bit d, input int wb_lat,
                          input int fill_lat, input bit miss_again, input bit drop_tag,
                          input bit drop_fill, input bit clr);
        mem_write = wr;
        mem_read = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        hit = h; valid = v; dirty = d;
        #1 outs("idle", 9'd0);
        tick;
        if (drop_tag) begin
            mem_read = 1'b0; mem_write = 1'b0;
            #1 outs("drop_tag", 9'd0);
            tick;
        end else if (h) begin
            clear_stats = clr;
            #1 outs("hit", {1'b1, 4'b0000, wr, 1'b0, wr, wr});
            tick;
            bump(m_hits);
            if (clr) begin m_hits = 0; m_misses = 0; end
        end else begin
            #1 outs("miss", 9'd0);
            tick;
            bump(m_misses);
            if (v && d) pmem_phase(1'b1, wb_lat, 1'b0);
            pmem_phase(1'b0, fill_lat, drop_fill);
            if (drop_fill) begin
                #1 outs("drop_retag", 9'd0);
                tick;
            end else begin
                if (miss_again) begin
                    hit = 1'b0; valid = 1'b1; dirty = 1'b0;
                    #1 outs("remiss", 9'd0);
                    tick;
                    pmem_phase(1'b0, fill_lat, 1'b0);
                end
                hit = 1'b1;
                #1 outs("retag_hit", {1'b1, 4'b0000, wr, 1'b0, wr, wr});
                tick;
            end
        end
        clear_stats = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0;
        #1 counts("after_req");
        outs("quiet", 9'd0);
        tick;
    endtask

    initial begin
        tick; tick;
        rst = 1'b0;
        #1 counts("reset");
        outs("reset_outs", 9'd0);
        pmem_resp = 1'b1;
        #1 outs("idle_ignores_resp", 9'd0);
        tick;
        pmem_resp = 1'b0;
        do_req(0, 1, 1, 0, 1, 1, 0, 0, 0, 0);
        do_req(1, 1, 1, 0, 1, 1, 0, 0, 0, 0);
        do_req(0, 0, 1, 0, 1, 4, 0, 0, 0, 0);
        do_req(1, 0, 1, 1, 3, 2, 0, 0, 0, 0);
        do_req(1, 0, 1, 0, 1, 2, 1, 0, 0, 0);
        do_req(0, 0, 1, 1, 2, 2, 0, 0, 1, 0);
        do_req(0, 1, 1, 0, 1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) do_req(1'($urandom_range(0, 1)), 1, 1, 0, 1, 1, 0, 0, 0, 0);
        chk("hit_saturated", 32'(hit_count), CMAX);
        do_req(0, 1, 1, 0, 1, 1, 0, 0, 0, 1);
        chk("clear_beats_inc", 32'(hit_count), 0);
        // reset while a fill is outstanding
        mem_read = 1'b1; hit = 1'b0; valid = 1'b0; dirty = 1'b0;
        tick; tick;
        #1 outs("alloc_before_rst", 9'b010000000);
        rst = 1'b1;
        tick;
        rst = 1'b0; mem_read = 1'b0;
        m_hits = 0; m_misses = 0;
        #1 outs("after_rst", 9'd0);
        counts("after_rst");
        for (int i = 0; i < 60; i++) begin
            bit h = 1'($urandom_range(0, 2) == 0);
            do_req(1'($urandom_range(0, 1)), h, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(1, 4), $urandom_range(1, 4), 1'($urandom_range(0, 4) == 0),
                   1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 7) == 0),
                   1'($urandom_range(0, 9) == 0));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
